tlv5618_sched: RTL

- Frame scheduler in front of the tlv5618 serial driver. Arbitrates channel A and channel B update requests and builds the 16-bit TLV5618 control word. Pulses the driver's start, then waits for its done pulse.
- When both channels request in the same cycle, it uses the buffer-then-A-with-update sequence so both outputs change together.
- Sits between application logic (key/waveform sources) and tlv5618.

---
 rtl/tlv5618_pkg.sv | 36 +++
 rtl/tlv5618_sched.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tlv5618_pkg.sv
// Shared definitions for the TLV5618 frame scheduler: command encodings,
// control-word bit positions, FSM state encoding and a word builder.
package tlv5618_pkg;

  localparam logic [1:0] CMD_WR_B     = 2'b00;
  localparam logic [1:0] CMD_WR_BUF   = 2'b01;
  localparam logic [1:0] CMD_WR_A_UPD = 2'b10;

  localparam int BIT_R1  = 15;
  localparam int BIT_SPD = 14;
  localparam int BIT_PWR = 13;
  localparam int BIT_R0  = 12;
  localparam int CODE_W  = 12;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } sched_state_t;

  function automatic logic [15:0] make_word(input logic [1:0]        cmd,
                                            input logic              spd,
                                            input logic              pwr,
                                            input logic [CODE_W-1:0] code);
    logic [15:0] w;
    w              = '0;
    w[BIT_R1]      = cmd[1];
    w[BIT_SPD]     = spd;
    w[BIT_PWR]     = pwr;
    w[BIT_R0]      = cmd[0];
    w[CODE_W-1:0]  = code;
    return w;
  endfunction

endpackage

// File: rtl/tlv5618_sched.sv
// Arbitrates channel A/B update requests into TLV5618 control frames, handles
// the paired buffer-then-A sequence, done handshake, timeout abort and gap.
module tlv5618_sched
  import tlv5618_pkg::*;
#(
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TW          = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [11:0] code_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [11:0] code_b,
  output logic        ack_b,
  input  logic        spd,
  input  logic        pwr,
  output logic [15:0] dac_data,
  output logic        dac_start,
  input  logic        dac_done,
  output logic        busy,
  output logic        err
);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

  sched_state_t  state, state_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic          pair_pend, pair_pend_nx;
  logic [15:0]   pend_word, pend_word_nx;
  logic [15:0]   dac_data_nx;

  // rst_n is active-high despite its name; acks are also gated by it so a
  // requester never sees an acceptance that the registers did not capture.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pair_pend <= 1'b0;
      pend_word <= '0;
      dac_data  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pair_pend <= pair_pend_nx;
      pend_word <= pend_word_nx;
      dac_data  <= dac_data_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pair_pend_nx = pair_pend;
    pend_word_nx = pend_word;
    dac_data_nx  = dac_data;
    ack_a        = 1'b0;
    ack_b        = 1'b0;
    dac_start    = 1'b0;
    err          = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rst_n) begin
          if (req_a && req_b) begin
            ack_a        = 1'b1;
            ack_b        = 1'b1;
            dac_data_nx  = make_word(CMD_WR_BUF, spd, pwr, code_b);
            pend_word_nx = make_word(CMD_WR_A_UPD, spd, pwr, code_a);
            pair_pend_nx = 1'b1;
            state_nx     = ISSUE;
          end else if (req_a) begin
            ack_a       = 1'b1;
            dac_data_nx = make_word(CMD_WR_A_UPD, spd, pwr, code_a);
            state_nx    = ISSUE;
          end else if (req_b) begin
            ack_b       = 1'b1;
            dac_data_nx = make_word(CMD_WR_B, spd, pwr, code_b);
            state_nx    = ISSUE;
          end
        end
      end

      ISSUE: begin
        dac_start = 1'b1;
        cnt_nx    = '0;
        state_nx  = WAIT;
      end

      // A timeout abandons any pending second frame of a pair.
      WAIT: begin
        if (dac_done) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end else if (cnt == TO_LAST) begin
          err          = 1'b1;
          pair_pend_nx = 1'b0;
          cnt_nx       = '0;
          state_nx     = GAP;
        end else begin
          cnt_nx = cnt + TW'(1);
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
          if (pair_pend) begin
            dac_data_nx  = pend_word;
            pair_pend_nx = 1'b0;
            state_nx     = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + TW'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
